// File: rtl/serial_rr_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// serial_rr_scheduler_pkg
// Shared definitions for the serial round-robin scheduler:
//   - state_t      : FSM state encoding (IDLE=0, HDR=1, PAY=2, DONE=3)
//   - DEF_NUM_CH   : default number of requesting channels
//   - DEF_LEN_W    : default header / counter width
// ---------------------------------------------------------------------------
package serial_rr_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_LEN_W  = 4;

endpackage

// File: rtl/serial_rr_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Searches req upward starting at
// rr_ptr+1, wrapping modulo NUM_CH, and returns the first set index.
// Ports:
//   req     in  NUM_CH  request vector
//   rr_ptr  in  SEL_W   last served channel (lowest priority this round)
//   winner  out SEL_W   index of the selected channel (0 when none)
//   any_req out 1       at least one request is set
// NUM_CH must be a power of two so the index addition wraps naturally.
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  rr_ptr,
    output logic [SEL_W-1:0]  winner,
    output logic              any_req
);

    // w_rot[k] is the request of the channel k+1 positions past rr_ptr,
    // so position 0 carries the highest priority.
    logic [SEL_W-1:0]  w_idx [NUM_CH];
    logic [NUM_CH-1:0] w_rot;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_rot
            assign w_idx[gi] = rr_ptr + SEL_W'(gi + 1);
            assign w_rot[gi] = req[w_idx[gi]];
        end
    endgenerate

    // Descending scan: the lowest rotated position that is set wins last.
    always_comb begin
        winner = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                winner = w_idx[i];
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/serial_rr_scheduler.sv
// ---------------------------------------------------------------------------
// serial_rr_scheduler
// Shares one serial receive/forward path among NUM_CH requesters. The
// granted channel sends a LEN_W-bit length header MSB-first, then that
// many payload bits are forwarded with a valid strobe, then done pulses
// and the grant is released.
// Ports:
//   clk           in  1       rising-edge clock
//   rst           in  1       synchronous active-high reset
//   req           in  NUM_CH  per-channel level request
//   ser_in        in  NUM_CH  per-channel serial data
//   grant         out NUM_CH  registered one-hot grant, zero when idle
//   busy          out 1       FSM not in IDLE
//   ser_out       out 1       ser_in of granted channel during payload
//   ser_out_valid out 1       high during payload-forwarding cycles
//   len_out       out LEN_W   last captured header value
//   done          out 1       one-cycle end-of-transfer pulse
// ---------------------------------------------------------------------------
module serial_rr_scheduler
    import serial_rr_scheduler_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] ser_in,
    output logic [NUM_CH-1:0] grant,
    output logic              busy,
    output logic              ser_out,
    output logic              ser_out_valid,
    output logic [LEN_W-1:0]  len_out,
    output logic              done
);

    localparam int SEL_W = $clog2(NUM_CH);

    state_t            r_state,  w_state_next;
    logic [NUM_CH-1:0] r_grant,  w_grant_next;
    logic [SEL_W-1:0]  r_sel,    w_sel_next;
    logic [SEL_W-1:0]  r_rr_ptr, w_rr_ptr_next;
    logic [LEN_W-1:0]  r_cnt,    w_cnt_next;
    logic [LEN_W-1:0]  r_hdr,    w_hdr_next;
    logic [LEN_W-1:0]  r_len,    w_len_next;

    logic [SEL_W-1:0]  w_winner;
    logic              w_any_req;
    logic              w_ser_bit;
    logic [LEN_W-1:0]  w_hdr_shift;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req     (req),
        .rr_ptr  (r_rr_ptr),
        .winner  (w_winner),
        .any_req (w_any_req)
    );

    assign w_ser_bit   = ser_in[r_sel];
    // Header value including the bit arriving this cycle; on the last
    // header cycle this is the complete length.
    assign w_hdr_shift = {r_hdr[LEN_W-2:0], w_ser_bit};

    always_comb begin
        w_state_next  = r_state;
        w_grant_next  = r_grant;
        w_sel_next    = r_sel;
        w_rr_ptr_next = r_rr_ptr;
        w_cnt_next    = r_cnt;
        w_hdr_next    = r_hdr;
        w_len_next    = r_len;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_grant_next = NUM_CH'(1) << w_winner;
                    w_sel_next   = w_winner;
                    w_cnt_next   = LEN_W'(LEN_W - 1);
                    w_state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                w_hdr_next = w_hdr_shift;
                w_cnt_next = r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    w_len_next = w_hdr_shift;
                    if (w_hdr_shift == '0) begin
                        w_state_next = ST_DONE;
                    end else begin
                        // Counting length-1 down to 0 keeps a full-scale
                        // length inside LEN_W bits.
                        w_cnt_next   = w_hdr_shift - 1'b1;
                        w_state_next = ST_PAY;
                    end
                end
            end
            ST_PAY: begin
                w_cnt_next = r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_grant_next  = '0;
                w_rr_ptr_next = r_sel;
                w_state_next  = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_sel    <= '0;
            r_rr_ptr <= SEL_W'(NUM_CH - 1);
            r_cnt    <= '0;
            r_hdr    <= '0;
            r_len    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_grant  <= w_grant_next;
            r_sel    <= w_sel_next;
            r_rr_ptr <= w_rr_ptr_next;
            r_cnt    <= w_cnt_next;
            r_hdr    <= w_hdr_next;
            r_len    <= w_len_next;
        end
    end

    assign grant         = r_grant;
    assign busy          = (r_state != ST_IDLE);
    assign ser_out_valid = (r_state == ST_PAY);
    assign ser_out       = (r_state == ST_PAY) ? w_ser_bit : 1'b0;
    assign done          = (r_state == ST_DONE);
    assign len_out       = r_len;

endmodule

// File: tb/tb_serial_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_serial_rr_scheduler
// Scenario tasks drive the scheduler and check control outputs inline.
// Expected payload bits and end-of-transfer records are pushed to queues
// as stimulus is driven; a negedge monitor pops and compares them when the
// DUT presents valid payload or a done pulse.
// ---------------------------------------------------------------------------
module tb_serial_rr_scheduler;

    typedef struct packed {
        logic [3:0] grant;
        logic [3:0] len;
    } done_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] ser_in;
    logic [3:0] grant;
    logic       busy;
    logic       ser_out;
    logic       ser_out_valid;
    logic [3:0] len_out;
    logic       done;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;

    logic  exp_bits [$];
    done_t exp_done [$];

    serial_rr_scheduler #(.NUM_CH(4), .LEN_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .ser_in        (ser_in),
        .grant         (grant),
        .busy          (busy),
        .ser_out       (ser_out),
        .ser_out_valid (ser_out_valid),
        .len_out       (len_out),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (ser_out_valid === 1'b1) begin
            checks++;
            if (exp_bits.size() == 0) begin
                errors++;
                $display("FAIL payload_unexpected: ser_out_valid=1 with no expected bit");
            end else begin
                logic e;
                e = exp_bits.pop_front();
                if (ser_out !== e) begin
                    errors++;
                    $display("FAIL payload_bit: ser_out=%b expected=%b", ser_out, e);
                end
            end
        end
        if (done === 1'b1) begin
            done_seen++;
            checks++;
            if (exp_done.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: done=1 grant=%b len_out=%0d", grant, len_out);
            end else begin
                done_t d;
                d = exp_done.pop_front();
                if (grant !== d.grant || len_out !== d.len) begin
                    errors++;
                    $display("FAIL done_record: grant=%b len_out=%0d expected grant=%b len=%0d",
                             grant, len_out, d.grant, d.len);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transfer starting from an IDLE cycle. chg_at: payload index at which
    // req becomes req_chg (-1 none). abort_at: payload index whose cycle has
    // rst asserted (-1 none).
    task automatic send(input logic [3:0] req_val, input int ch, input logic [3:0] hdr,
                        input logic [14:0] pay, input int chg_at, input logic [3:0] req_chg,
                        input int abort_at);
        logic [3:0] oh;
        oh  = 4'b0001 << ch;
        req = req_val;
        ser_in = 4'($urandom_range(0, 15));
        tick();
        checks++;
        if (grant !== oh || busy !== 1'b1) begin
            errors++;
            $display("FAIL grant_start: grant=%b busy=%b expected grant=%b busy=1", grant, busy, oh);
        end
        for (int k = 0; k < 4; k++) begin
            ser_in = 4'($urandom_range(0, 15));
            ser_in[ch] = hdr[3-k];
            #1;
            checks++;
            if (ser_out_valid !== 1'b0 || ser_out !== 1'b0 || grant !== oh || done !== 1'b0) begin
                errors++;
                $display("FAIL hdr_phase: valid=%b ser_out=%b grant=%b done=%b expected 0,0,%b,0",
                         ser_out_valid, ser_out, grant, done, oh);
            end
            tick();
        end
        checks++;
        if (len_out !== hdr) begin
            errors++;
            $display("FAIL len_out: got=%0d expected=%0d", len_out, hdr);
        end
        for (int i = 0; i < int'(hdr); i++) begin
            if (i == chg_at) req = req_chg;
            ser_in = 4'($urandom_range(0, 15));
            ser_in[ch] = pay[i];
            exp_bits.push_back(pay[i]);
            if (i == abort_at) rst = 1'b1;
            #1;
            checks++;
            if (ser_out_valid !== 1'b1 || grant !== oh || done !== 1'b0) begin
                errors++;
                $display("FAIL pay_phase: valid=%b grant=%b done=%b expected 1,%b,0",
                         ser_out_valid, grant, done, oh);
            end
            tick();
            if (i == abort_at) begin
                rst = 1'b0;
                #1;
                checks++;
                if (grant !== 4'b0 || busy !== 1'b0 || ser_out_valid !== 1'b0 ||
                    ser_out !== 1'b0 || done !== 1'b0 || len_out !== 4'd0) begin
                    errors++;
                    $display("FAIL abort_outputs: grant=%b busy=%b valid=%b ser_out=%b done=%b len=%0d expected all 0",
                             grant, busy, ser_out_valid, ser_out, done, len_out);
                end
                return;
            end
        end
        exp_done.push_back('{grant: oh, len: hdr});
        #1;
        checks++;
        if (done !== 1'b1 || ser_out_valid !== 1'b0 || grant !== oh) begin
            errors++;
            $display("FAIL done_phase: done=%b valid=%b grant=%b expected 1,0,%b",
                     done, ser_out_valid, grant, oh);
        end
        tick();
        checks++;
        if (grant !== 4'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL release: grant=%b done=%b busy=%b expected 0,0,0", grant, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0;
        ser_in = 4'b0;
        tick();
        tick();
        checks++;
        if (grant !== 4'b0 || busy !== 1'b0 || ser_out !== 1'b0 || ser_out_valid !== 1'b0 ||
            len_out !== 4'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: grant=%b busy=%b ser_out=%b valid=%b len=%0d done=%b expected all 0",
                     grant, busy, ser_out, ser_out_valid, len_out, done);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (grant !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: grant=%b busy=%b expected 0,0", grant, busy);
        end
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        int d0;
        d0 = done_seen;
        send(4'b0100, 2, 4'b1011, 15'($urandom), -1, 4'b0, -1);
        req = 4'b0;
        checks++;
        if (exp_bits.size() != 0 || done_seen - d0 != 1) begin
            errors++;
            $display("FAIL basic_count: leftover_bits=%0d dones=%0d expected 0,1",
                     exp_bits.size(), done_seen - d0);
        end
        $display("test_basic: ch2 len 11 transfer complete");
    endtask

    task automatic test_zero_len();
        int d0;
        d0 = done_seen;
        send(4'b0001, 0, 4'b0000, 15'($urandom), -1, 4'b0, -1);
        req = 4'b0;
        checks++;
        if (len_out !== 4'd0 || done_seen - d0 != 1) begin
            errors++;
            $display("FAIL zero_len: len_out=%0d dones=%0d expected 0,1", len_out, done_seen - d0);
        end
        $display("test_zero_len: ch0 empty transfer complete");
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send(4'b1111, k % 4, 4'b0001, 15'($urandom), -1, 4'b0, -1);
            $display("test_back_to_back: transfer %0d on ch%0d", k, k % 4);
        end
        req = 4'b0;
    endtask

    task automatic test_hold_grant();
        send(4'b0010, 1, 4'b0101, 15'($urandom), 2, 4'b1000, -1);
        $display("test_hold_grant: ch1 completed with req dropped mid-payload");
        send(4'b1000, 3, 4'b0011, 15'($urandom), -1, 4'b0, -1);
        req = 4'b0;
        $display("test_hold_grant: ch3 served after ch1");
    endtask

    task automatic test_max_len();
        int d0;
        d0 = done_seen;
        send(4'b0101, 0, 4'b1111, 15'($urandom), -1, 4'b0, -1);
        req = 4'b0;
        checks++;
        if (exp_bits.size() != 0 || done_seen - d0 != 1) begin
            errors++;
            $display("FAIL max_len_count: leftover_bits=%0d dones=%0d expected 0,1",
                     exp_bits.size(), done_seen - d0);
        end
        $display("test_max_len: ch0 len 15 transfer complete");
    endtask

    task automatic test_reset_mid();
        int d0;
        send(4'b0010, 1, 4'b0000, 15'($urandom), -1, 4'b0, -1);
        d0 = done_seen;
        send(4'b0100, 2, 4'b1000, 15'($urandom), -1, 4'b0, 3);
        req = 4'b1010;
        tick();
        checks++;
        if (grant !== 4'b0010 || done_seen != d0) begin
            errors++;
            $display("FAIL rearb_after_reset: grant=%b dones=%0d expected grant=0010 dones=0",
                     grant, done_seen - d0);
        end
        req = 4'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (exp_bits.size() != 0 || grant !== 4'b0) begin
            errors++;
            $display("FAIL reset_mid_final: leftover_bits=%0d grant=%b expected 0,0000",
                     exp_bits.size(), grant);
        end
        $display("test_reset_mid: abort and re-arbitration done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_back_to_back();
        test_hold_grant();
        test_max_len();
        test_reset_mid();
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_rr_scheduler.md
Name: serial_rr_scheduler

Overview:
- Shares one serial receive/forward datapath among NUM_CH serial requesters using round-robin arbitration.
- For the granted channel: captures a LEN_W-bit length header MSB-first, forwards exactly that many payload bits with a valid strobe, then pulses done and releases the grant.
- Sits in front of the shift/count/buffer path and takes over the sequencing its controller currently does for a single source.

Parameters:
- NUM_CH, 4, number of requesting channels (power of two, ≥2).
- LEN_W, 4, header width; payload length range 0..2^LEN_W-1 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  NUM_CH  per-channel transfer request, level.
- ser_in  input  NUM_CH  per-channel serial data.
- grant  output  NUM_CH  one-hot registered grant; all-zero when idle.
- busy  output  1  high in any state other than IDLE.
- ser_out  output  1  ser_in of the granted channel while ser_out_valid = 1, else 0.
- ser_out_valid  output  1  high exactly during payload-forwarding cycles.
- len_out  output  LEN_W  captured header value, held until the next header capture.
- done  output  1  one-cycle pulse at the end of each transfer.

Behaviour:
- Reset is synchronous, active-high: state=IDLE, grant=0, rr_ptr=NUM_CH-1, hdr shift register=0, bit counter=0, len_out=0.
  - Outputs: busy=0, ser_out=0, ser_out_valid=0, done=0.
  - An rst during any state aborts the transfer at that edge; no done pulse is issued.
- Moore FSM with states IDLE, HDR, PAY, DONE.
  - ser_out_valid = (state==PAY); done = (state==DONE); busy = (state!=IDLE).
- IDLE:
  - If req≠0, select the winner by round-robin: first set req bit searching upward from rr_ptr+1, wrapping modulo NUM_CH.
  - Next edge: grant←onehot(winner), sel←winner, bit counter←LEN_W-1, state←HDR.
  - If req=0, stay in IDLE with grant=0.
- HDR (exactly LEN_W cycles):
  - Each edge shifts ser_in[sel] into the LSB of hdr (first bit received ends as MSB) and decrements the counter.
  - At the edge where counter==0:
    - len_out←completed header value.
    - If that value is 0: state←DONE (PAY skipped).
    - Otherwise: payload counter←value-1, state←PAY.
- PAY (exactly len_out cycles):
  - ser_out follows ser_in[sel] combinationally (zero latency).
  - Counter decrements each edge; at the edge where counter==0, state←DONE.
- DONE (exactly 1 cycle): done=1, grant still asserted. Next edge: grant←0, rr_ptr←sel, state←IDLE.
- Grant is held for the whole transfer, whatever happens on req:
  - Deasserting req[sel] mid-transfer is ignored; the transfer completes.
  - New requests from other channels wait.
- Minimum turnaround: DONE→IDLE→HDR, so back-to-back transfers have one idle cycle between them.
- Fairness:
  - The channel just served has lowest priority in the next arbitration.
  - With all req held high, grants rotate 0,1,2,3,0,…
- Width rules:
  - Counters are LEN_W bits.
  - Payload of 2^LEN_W-1 must not overflow.
  - sel is clog2(NUM_CH) bits.

Decomposition:
- Shared package: state encoding constants (IDLE=0, HDR=1, PAY=2, DONE=3) and default LEN_W/NUM_CH constants.
- One sub-module, rr_arbiter: combinational round-robin priority pick.
  - Inputs: req, rr_ptr. Outputs: winner index, any_req.
  - Reusable elsewhere.
- FSM, counters, header register and output muxing stay in serial_rr_scheduler.

Test Plan:
- Reset then req=4'b0100, ch2 serial 1,0,1,1 then 11 payload bits:
  - grant=4'b0100 one cycle after req.
  - len_out=11 after 4 header cycles.
  - ser_out_valid high exactly 11 cycles with ser_out = ch2 payload.
  - done one cycle, then grant=0.
- Header 0000 on ch0: HDR 4 cycles → DONE directly; ser_out_valid never asserts; done pulses once; len_out=0.
- req=4'b1111 held, every header=0001:
  - Grant sequence 0001,0010,0100,1000,0001.
  - Each transfer 4+1+1 cycles plus one IDLE cycle.
- During ch1 PAY, drop req[1] and raise req[3]: ch1 payload completes in full; ch3 is granted only after ch1 done.
- Header 1111: exactly 15 valid cycles, counter does not wrap, single done.
- Assert rst for one cycle mid-PAY: next cycle all outputs 0, state IDLE, no done; a pending req is re-arbitrated from rr_ptr=NUM_CH-1, so lowest set channel wins.
